// File: rtl/mips32_pkg.sv
// Shared definitions for the pipe_mips32 boot loader: loader FSM states,
// host header field positions and the HLT opcode shared with the core.
package mips32_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HDR_D,
        S_LOAD,
        S_CSUM,
        S_START,
        S_RUN,
        S_DUMP_RD,
        S_DUMP_OUT,
        S_DONE,
        S_ERR
    } loader_state_t;

    // Both header words carry a count in the upper half and a base in the lower half.
    localparam int HDR_CNT_MSB  = 31;
    localparam int HDR_CNT_LSB  = 16;
    localparam int HDR_BASE_MSB = 15;
    localparam int HDR_BASE_LSB = 0;

    // Opcode field value of the halt instruction, as decoded by the core.
    localparam logic [5:0] HLT = 6'h3f;

endpackage

// File: rtl/mips32_boot_loader_if.sv
// Bus bundle between the loader and its environment: host input word stream,
// the loader's port onto unified memory, and the host dump word stream.
// The loader uses the master view; host and memory use the slave view.
interface mips32_boot_loader_if #(
    parameter int AW = 10
);
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          mem_we;
    logic          mem_re;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_data;

    modport master (
        input  in_valid, in_data, mem_rdata, out_ready,
        output in_ready, mem_we, mem_re, mem_addr, mem_wdata, out_valid, out_data
    );

    modport slave (
        output in_valid, in_data, mem_rdata, out_ready,
        input  in_ready, mem_we, mem_re, mem_addr, mem_wdata, out_valid, out_data
    );
endinterface

// File: rtl/mips32_loader_wdog.sv
// Run watchdog: counts enabled cycles and raises o_sat on the enabled cycle
// that brings the counter to all-ones, i.e. after 2^TIMEOUT_W-1 run cycles.
// The counter never wraps; clear returns it to zero.
module mips32_loader_wdog #(
    parameter int TIMEOUT_W = 16
) (
    input  logic clk1,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_sat
);
    localparam logic [TIMEOUT_W-1:0] LP_MAX  = '1;
    localparam logic [TIMEOUT_W-1:0] LP_LAST = LP_MAX - TIMEOUT_W'(1);

    logic [TIMEOUT_W-1:0] r_cnt;

    // Saturating run-cycle counter.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != LP_MAX)) begin
            r_cnt <= r_cnt + TIMEOUT_W'(1);
        end
    end

    assign o_sat = i_en && (r_cnt == LP_LAST);

endmodule

// File: rtl/mips32_boot_loader.sv
// Program loader / result dumper for pipe_mips32. Holds the core in reset,
// writes the host image into memory, releases the core until it halts, then
// streams a memory window back to the host.
// Optional build macro MIPS32_LOADER_CSUM_EN: expect a trailing checksum word
// (mod-2^32 sum of the data words) and refuse to start the core on mismatch.
module mips32_boot_loader
    import mips32_pkg::*;
#(
    parameter int AW        = 10,
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk1,
    input  logic                 rst_n,
    mips32_boot_loader_if.master bus,
    output logic                 cpu_rst_n,
    input  logic                 cpu_halted,
    output logic                 busy,
    output logic                 done,
    output logic                 error
);

`ifdef MIPS32_LOADER_CSUM_EN
    localparam loader_state_t LP_AFTER_LOAD = S_CSUM;
`else
    localparam loader_state_t LP_AFTER_LOAD = S_START;
`endif

    loader_state_t r_state, w_state_next;

    logic          r_armed;      // low only until the first clock after reset
    logic          r_cpu_rst_n;
    logic          r_rd_pend;    // memory read data arrives this cycle
    logic [15:0]   r_nl, r_nd;
    logic [AW-1:0] r_bl, r_bd;
    logic [15:0]   r_idx;        // load word index, later dump word index
    logic [31:0]   r_out_data;
`ifdef MIPS32_LOADER_CSUM_EN
    logic [31:0]   r_sum;
`endif

    logic [15:0]   w_idx_inc;
    logic          w_in_ready, w_in_fire, w_run, w_wdog_sat;
    logic          w_mem_we, w_mem_re;
    logic [AW-1:0] w_mem_addr;
    logic [31:0]   w_mem_wdata;

    assign w_idx_inc  = r_idx + 16'd1;
    assign w_in_ready = r_armed && (r_state inside {S_IDLE, S_HDR_D, S_LOAD, S_CSUM});
    assign w_in_fire  = bus.in_valid && w_in_ready;
    assign w_run      = (r_state == S_RUN);

    mips32_loader_wdog #(.TIMEOUT_W(TIMEOUT_W)) u_wdog (
        .clk1  (clk1),
        .rst_n (rst_n),
        .i_clr (!w_run),
        .i_en  (w_run),
        .o_sat (w_wdog_sat)
    );

    // State register.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Next state plus the combinational memory strobes (writes follow the handshake).
    always_comb begin
        w_state_next = r_state;
        w_mem_we     = 1'b0;
        w_mem_re     = 1'b0;
        w_mem_addr   = '0;
        w_mem_wdata  = '0;
        case (r_state)
            S_IDLE:  if (w_in_fire) w_state_next = S_HDR_D;
            S_HDR_D: if (w_in_fire) w_state_next = (r_nl == 16'd0) ? LP_AFTER_LOAD : S_LOAD;
            S_LOAD: begin
                if (w_in_fire) begin
                    w_mem_we    = 1'b1;
                    w_mem_addr  = r_bl + r_idx[AW-1:0];
                    w_mem_wdata = bus.in_data;
                    if (w_idx_inc == r_nl) w_state_next = LP_AFTER_LOAD;
                end
            end
`ifdef MIPS32_LOADER_CSUM_EN
            S_CSUM:  if (w_in_fire) w_state_next = (bus.in_data == r_sum) ? S_START : S_ERR;
`endif
            S_START: w_state_next = S_RUN;
            S_RUN: begin
                // A halt on the same cycle as the timeout still counts as success.
                if (cpu_halted)      w_state_next = (r_nd == 16'd0) ? S_DONE : S_DUMP_RD;
                else if (w_wdog_sat) w_state_next = S_ERR;
            end
            S_DUMP_RD: begin
                w_mem_re     = 1'b1;
                w_mem_addr   = r_bd + r_idx[AW-1:0];
                w_state_next = S_DUMP_OUT;
            end
            S_DUMP_OUT: if (bus.out_ready) w_state_next = (w_idx_inc == r_nd) ? S_DONE : S_DUMP_RD;
            default: ;
        endcase
    end

    // Header capture, word indexing, checksum and dump data holding.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            r_armed     <= 1'b0;
            r_cpu_rst_n <= 1'b0;
            r_rd_pend   <= 1'b0;
            r_nl        <= '0;
            r_nd        <= '0;
            r_bl        <= '0;
            r_bd        <= '0;
            r_idx       <= '0;
            r_out_data  <= '0;
`ifdef MIPS32_LOADER_CSUM_EN
            r_sum       <= '0;
`endif
        end else begin
            r_armed     <= 1'b1;
            // Registered so the core reset is glitch-free; high exactly while in RUN.
            r_cpu_rst_n <= (w_state_next == S_RUN);
            r_rd_pend   <= (r_state == S_DUMP_RD);
            if (r_rd_pend) r_out_data <= bus.mem_rdata;
            if (w_in_fire) begin
                case (r_state)
                    S_IDLE: begin
                        r_nl <= bus.in_data[HDR_CNT_MSB:HDR_CNT_LSB];
                        r_bl <= bus.in_data[HDR_BASE_LSB +: AW];
                    end
                    S_HDR_D: begin
                        r_nd  <= bus.in_data[HDR_CNT_MSB:HDR_CNT_LSB];
                        r_bd  <= bus.in_data[HDR_BASE_LSB +: AW];
                        r_idx <= '0;
`ifdef MIPS32_LOADER_CSUM_EN
                        r_sum <= '0;
`endif
                    end
                    S_LOAD: begin
                        r_idx <= w_idx_inc;
`ifdef MIPS32_LOADER_CSUM_EN
                        r_sum <= r_sum + bus.in_data;
`endif
                    end
                    default: ;
                endcase
            end
            if (r_state == S_START) r_idx <= '0;
            if ((r_state == S_DUMP_OUT) && bus.out_ready) r_idx <= w_idx_inc;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_re    = w_mem_re;
    assign bus.mem_addr  = w_mem_addr;
    assign bus.mem_wdata = w_mem_wdata;
    assign bus.out_valid = (r_state == S_DUMP_OUT);
    // First DUMP_OUT cycle passes the fresh read data; later cycles hold the captured copy.
    assign bus.out_data  = r_rd_pend ? bus.mem_rdata : r_out_data;
    assign cpu_rst_n     = r_cpu_rst_n;
    assign busy          = !(r_state inside {S_IDLE, S_DONE, S_ERR});
    assign done          = (r_state == S_DONE);
    assign error         = (r_state == S_ERR);

endmodule

// File: tb/tb_mips32_boot_loader.sv
// Directed bench for mips32_boot_loader: program load and dump, dump
// backpressure, zero counts, address wrap, run watchdog, optional checksum
// error and asynchronous reset mid-load. A simple core model stands in for
// pipe_mips32 and the memory model owns all memory state.
`timescale 1ns/1ps
module tb_mips32_boot_loader;
    localparam int AW = 10;
    localparam int TW = 4;

    logic clk1 = 1'b0;
    logic rst_n = 1'b1;
    logic cpu_rst_n, cpu_halted, busy, done, error;

    always #5 clk1 = ~clk1;

    mips32_boot_loader_if #(.AW(AW)) bif ();

    mips32_boot_loader #(.AW(AW), .TIMEOUT_W(TW)) dut (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .bus        (bif),
        .cpu_rst_n  (cpu_rst_n),
        .cpu_halted (cpu_halted),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]   mem [0:(1<<AW)-1];
    logic [31:0]   wr_addr_log [0:15];
    logic [31:0]   wr_data_log [0:15];
    logic [31:0]   img [0:7];
    int            we_cnt = 0;
    int            re_cnt = 0;
    int            core_cyc = 0;
    int            halt_at = 4;
    logic          poke_en = 1'b0;
    logic [AW-1:0] poke_addr = '0;
    logic [31:0]   poke_data = '0;

    // Memory model (registered read) plus a minimal core: one cycle-count
    // program that stores Mem[120]+45 to Mem[121] and then halts.
    always @(posedge clk1) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        if (bif.mem_we) begin
            mem[bif.mem_addr] <= bif.mem_wdata;
            if (we_cnt < 16) begin
                wr_addr_log[we_cnt] <= 32'(bif.mem_addr);
                wr_data_log[we_cnt] <= bif.mem_wdata;
            end
            we_cnt <= we_cnt + 1;
        end
        if (bif.mem_re) begin
            bif.mem_rdata <= mem[bif.mem_addr];
            re_cnt <= re_cnt + 1;
        end
        if (!rst_n) begin
            we_cnt <= 0;
            re_cnt <= 0;
        end
        if (!cpu_rst_n) begin
            core_cyc   <= 0;
            cpu_halted <= 1'b0;
        end else if (!cpu_halted) begin
            core_cyc <= core_cyc + 1;
            if (core_cyc == 2) mem[121] <= mem[120] + 32'd45;
            if (core_cyc == halt_at) cpu_halted <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ctrl_vec();
        return {24'd0, bif.in_ready, bif.mem_we, bif.mem_re, cpu_rst_n,
                bif.out_valid, busy, done, error};
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_ctrl"},  ctrl_vec(), 32'd0);
        check({tag, "_addr"},  32'(bif.mem_addr), 32'd0);
        check({tag, "_wdata"}, bif.mem_wdata, 32'd0);
        check({tag, "_odata"}, bif.out_data, 32'd0);
    endtask

    // Called at a falling edge; returns at the falling edge after the handshake.
    task automatic send_word(input logic [31:0] d);
        int t;
        t = 0;
        bif.in_valid = 1'b1;
        bif.in_data  = d;
        while (bif.in_ready !== 1'b1 && t < 20) begin
            @(negedge clk1);
            t++;
        end
        check("in_ready_wait", {31'd0, bif.in_ready}, 32'd1);
        @(negedge clk1);
        bif.in_valid = 1'b0;
        $display("host->loader word 0x%08h", d);
    endtask

    task automatic recv_word(output logic [31:0] d);
        int t;
        t = 0;
        bif.out_ready = 1'b1;
        while (bif.out_valid !== 1'b1 && t < 30) begin
            @(negedge clk1);
            t++;
        end
        check("out_valid_wait", {31'd0, bif.out_valid}, 32'd1);
        d = bif.out_data;
        @(negedge clk1);
        bif.out_ready = 1'b0;
        $display("loader->host dump word 0x%08h", d);
    endtask

    task automatic send_image(input logic [31:0] hl, input logic [31:0] hd, input int n);
`ifdef MIPS32_LOADER_CSUM_EN
        logic [31:0] s;
        s = '0;
`endif
        send_word(hl);
        send_word(hd);
        for (int i = 0; i < n; i++) begin
            send_word(img[i]);
`ifdef MIPS32_LOADER_CSUM_EN
            s = s + img[i];
`endif
        end
`ifdef MIPS32_LOADER_CSUM_EN
        send_word(s);
`endif
    endtask

    task automatic apply_reset();
        bif.in_valid  = 1'b0;
        bif.in_data   = '0;
        bif.out_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk1);
        rst_n = 1'b1;
    endtask

    task automatic wait_end(input int limit);
        int t;
        t = 0;
        while (done !== 1'b1 && error !== 1'b1 && t < limit) begin
            @(negedge clk1);
            t++;
        end
    endtask

    initial begin
        logic [31:0] d;
        logic        stable;
        int          run_cnt;
        logic [31:0] wrap_addr [0:3];

        bif.in_valid  = 1'b0;
        bif.in_data   = '0;
        bif.out_ready = 1'b0;

        // ---- reset values, then in_ready on first clock after release
        #1 rst_n = 1'b0;
        #1 check_reset_values("reset");
        repeat (2) @(negedge clk1);
        rst_n = 1'b1;
        check("in_ready_before_clk", {31'd0, bif.in_ready}, 32'd0);
        @(negedge clk1);
        check("in_ready_after_clk", {31'd0, bif.in_ready}, 32'd1);

        // ---- program load, run, dump with backpressure
        poke_en = 1'b1; poke_addr = 10'd120; poke_data = 32'd85;
        @(negedge clk1);
        poke_en = 1'b0;
        img[0] = 32'h28010078; img[1] = 32'h0c631800; img[2] = 32'h20220000; img[3] = 32'h0c631800;
        img[4] = 32'h2842002d; img[5] = 32'h0c631800; img[6] = 32'h24220001; img[7] = 32'hfc000000;
        send_word(32'h0008_0000);
        check("busy_after_hdr", {31'd0, busy}, 32'd1);
        send_word(32'h0002_0078);
        for (int i = 0; i < 8; i++) send_word(img[i]);
`ifdef MIPS32_LOADER_CSUM_EN
        send_word(32'h28010078 + 32'h0c631800 + 32'h20220000 + 32'h0c631800 +
                  32'h2842002d + 32'h0c631800 + 32'h24220001 + 32'hfc000000);
`endif
        check("start_cpu_held", {31'd0, cpu_rst_n}, 32'd0);
        @(negedge clk1);
        check("cpu_released", {31'd0, cpu_rst_n}, 32'd1);
        begin
            int t;
            t = 0;
            while (bif.out_valid !== 1'b1 && t < 40) begin
                @(negedge clk1);
                t++;
            end
        end
        check("dump0_valid", {31'd0, bif.out_valid}, 32'd1);
        check("dump0_data", bif.out_data, 32'd85);
        check("cpu_rst_fell", {31'd0, cpu_rst_n}, 32'd0);
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk1);
            if (bif.out_data !== 32'd85 || bif.out_valid !== 1'b1) stable = 1'b0;
        end
        check("backpressure_stable", {31'd0, stable}, 32'd1);
        recv_word(d);
        check("dump_word0", d, 32'd85);
        recv_word(d);
        check("dump_word1", d, 32'd130);
        wait_end(20);
        check("prog_status", ctrl_vec(), 32'h0000_0002);
        check("prog_we_cnt", 32'(we_cnt), 32'd8);
        check("prog_re_cnt", 32'(re_cnt), 32'd2);
        for (int i = 0; i < 8; i++) begin
            check("prog_wr_addr", wr_addr_log[i], 32'(i));
            check("prog_wr_data", wr_data_log[i], img[i]);
        end

        // ---- zero counts
        apply_reset();
        send_image(32'h0000_0000, 32'h0000_0000, 0);
        check("zero_start_held", {31'd0, cpu_rst_n}, 32'd0);
        @(negedge clk1);
        check("zero_cpu_released", {31'd0, cpu_rst_n}, 32'd1);
        wait_end(40);
        check("zero_status", ctrl_vec(), 32'h0000_0002);
        check("zero_we_cnt", 32'(we_cnt), 32'd0);
        check("zero_re_cnt", 32'(re_cnt), 32'd0);

        // ---- address wrap on load and dump, base truncated to AW bits
        apply_reset();
        img[0] = 32'hA0000001; img[1] = 32'hA0000002; img[2] = 32'hA0000003; img[3] = 32'hA0000004;
        wrap_addr[0] = 32'h3FE; wrap_addr[1] = 32'h3FF; wrap_addr[2] = 32'h000; wrap_addr[3] = 32'h001;
        send_image(32'h0004_FFFE, 32'h0003_03FF, 4);
        recv_word(d);
        check("wrap_dump0", d, 32'hA0000002);
        recv_word(d);
        check("wrap_dump1", d, 32'hA0000003);
        recv_word(d);
        check("wrap_dump2", d, 32'hA0000004);
        wait_end(20);
        check("wrap_done", {31'd0, done}, 32'd1);
        check("wrap_we_cnt", 32'(we_cnt), 32'd4);
        for (int i = 0; i < 4; i++) check("wrap_wr_addr", wr_addr_log[i], wrap_addr[i]);

        // ---- watchdog: core never halts
        apply_reset();
        halt_at = 1000;
        send_image(32'h0000_0000, 32'h0000_0000, 0);
        run_cnt = 0;
        begin
            int t;
            t = 0;
            while (error !== 1'b1 && t < 60) begin
                @(negedge clk1);
                if (cpu_rst_n === 1'b1) run_cnt++;
                t++;
            end
        end
        check("wdog_run_cycles", 32'(run_cnt), 32'd15);
        check("wdog_status", ctrl_vec(), 32'h0000_0001);
        halt_at = 4;

`ifdef MIPS32_LOADER_CSUM_EN
        // ---- checksum off by one: error, core never released
        apply_reset();
        send_word(32'h0002_0010);
        send_word(32'h0000_0000);
        send_word(32'd5);
        send_word(32'd7);
        send_word(32'd13);
        check("csum_error", ctrl_vec(), 32'h0000_0001);
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk1);
            if (cpu_rst_n !== 1'b0) stable = 1'b0;
        end
        check("csum_cpu_held", {31'd0, stable}, 32'd1);
        check("csum_we_cnt", 32'(we_cnt), 32'd2);
        check("csum_wr_addr1", wr_addr_log[1], 32'h11);
`endif

        // ---- asynchronous reset in the middle of LOAD
        apply_reset();
        send_word(32'h0004_0020);
        send_word(32'h0000_0000);
        send_word(32'h0000_0001);
        bif.in_valid = 1'b1;
        bif.in_data  = 32'h0000_0002;
        #1;
        check("midload_we", {31'd0, bif.mem_we}, 32'd1);
        check("midload_addr", 32'(bif.mem_addr), 32'h21);
        #1 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        bif.in_valid = 1'b0;
        @(negedge clk1);
        rst_n = 1'b1;
        @(negedge clk1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule

// File: doc/mips32_boot_loader.md
# mips32_boot_loader

Single-clock program loader and result dumper for the `pipe_mips32` core, sitting between a 32-bit host word stream and the core's unified instruction/data memory. The block holds the core in reset and writes a program image into memory. It then releases the core and waits for the HLT-driven `cpu_halted` flag. Finally it streams a requested memory window back to the host, replacing bench-side direct pokes of `Mem`, `PC`, `HALTED` and `TAKEN_BRANCH`.

## Interface
- `AW`, 10, memory word-address width.
- `TIMEOUT_W`, 16, width of the run watchdog counter; timeout fires after 2^TIMEOUT_W−1 run cycles.
- `clk1`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  host word valid.
- `in_ready`  out  1  loader accepts the word this cycle.
- `in_data`  in  32  host word.
- `mem_we`  out  1  memory write strobe.
- `mem_re`  out  1  memory read strobe; data returns next cycle.
- `mem_addr`  out  AW  memory word address.
- `mem_wdata`  out  32  write data.
- `mem_rdata`  in  32  read data, valid one cycle after `mem_re`.
- `cpu_rst_n`  out  1  core reset; low clears PC, HALTED and TAKEN_BRANCH.
- `cpu_halted`  in  1  core HALTED flag.
- `out_valid`  out  1  dump word valid.
- `out_ready`  in  1  host accepts dump word.
- `out_data`  out  32  dump word.
- `busy`, `done`, `error`  out  1 each  status.

## Operation
- Host protocol, in order:
  - HDR_L: `[31:16]` load count NL, `[15:0]` load base BL.
  - HDR_D: `[31:16]` dump count ND, `[15:0]` dump base BD.
  - NL data words.
  - Checksum word, only when enabled (see Configuration).
- Base fields are truncated to AW bits. Addresses increment modulo 2^AW and wrap silently.
- States: IDLE → HDR_D → LOAD → [CSUM] → START → RUN → DUMP_RD → DUMP_OUT → DONE; ERR is terminal.
  - IDLE: `in_ready`=1; capture HDR_L on handshake.
  - HDR_D: capture HDR_D; go to LOAD, or to START/CSUM if NL=0.
  - LOAD: `in_ready`=1. Each handshake drives `mem_we`=1, `mem_addr`=BL+i and `mem_wdata`=`in_data` in the same cycle, combinationally from the handshake. After the NL-th word, exit.
  - START: one cycle with `cpu_rst_n` still low, then RUN.
  - RUN: `cpu_rst_n`=1 and the watchdog counts. `cpu_halted`=1 goes to DUMP_RD, or to DONE if ND=0. Watchdog saturation goes to ERR with `cpu_rst_n` re-asserted low.
  - DUMP_RD: `mem_re`=1, `mem_addr`=BD+j, then go to DUMP_OUT.
  - DUMP_OUT: register `mem_rdata`, hold `out_valid`=1 until `out_ready`. On handshake, increment j; go to DUMP_RD or DONE.
  - DONE/ERR: `in_ready`=0. A new HDR_L is accepted only after reset.
- `in_ready`=0 in every state not listed as accepting.
- Counts are 16 bits. NL and ND may exceed 2^AW, in which case addresses wrap.
- `cpu_halted` during LOAD or START is ignored because the core is held in reset.
- Reset mid-operation aborts immediately. Memory contents are left as written.

## Timing
- Reset values: `in_ready`=0, `mem_we`=0, `mem_re`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_rst_n`=0, `out_valid`=0, `out_data`=0, `busy`=0, `done`=0, `error`=0. State is IDLE.
- `in_ready` rises on the first clock after reset release.
- One load word per cycle at full rate.
- Dump throughput is one word per two cycles at best (read, then present). `out_data` and `out_valid` stay stable until the handshake.
- `busy`=1 in every state other than IDLE, DONE and ERR. `done` and `error` are sticky until reset.
- `cpu_rst_n` rises exactly one cycle after the final load or checksum handshake. It falls back to low for the rest of operation one cycle after `cpu_halted` is sampled high.

## Configuration
- `MIPS32_LOADER_CSUM_EN` defined:
  - After NL data words, the loader expects one CSUM word equal to the modulo-2^32 sum of the data words.
  - On a match, go to START. On a mismatch, go to ERR: `error`=1, the core is never released, and memory keeps the written words.
- `MIPS32_LOADER_CSUM_EN` undefined: no CSUM state; LOAD goes directly to START.

## Structure
- Package `mips32_pkg` holds:
  - the state enum `loader_state_t`;
  - header field positions `HDR_CNT_MSB/LSB` and `HDR_BASE_MSB/LSB`;
  - the `HLT` opcode constant 6'h3f, shared with the core.
- Sub-module `mips32_loader_wdog` holds the run watchdog: a `TIMEOUT_W`-bit counter with clear, enable and saturate flag. Everything else stays in one module.

## Test plan
- Program load: HDR_L=0x0008_0000, HDR_D=0x0002_0078, then the eight-word program 28010078, 0c631800, 20220000, 0c631800, 2842002d, 0c631800, 24220001, fc000000. Memory model pre-set Mem[120]=85. Required: Mem[0..7] written in order, `cpu_rst_n` rises, core halts, dump yields 85 then 130, `done`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles during the dump → `out_data` stays constant at 85 and no word is lost or duplicated.
- Zero counts: NL=0, ND=0 → the core runs straight away; on halt `done`=1 with no `mem_we`/`mem_re` pulses at all.
- Wrap: AW=10, BL=0x3FE, NL=4 → writes go to 0x3FE, 0x3FF, 0x000, 0x001.
- Watchdog: `cpu_halted` tied 0, TIMEOUT_W=4 → `error`=1 after 15 RUN cycles and `cpu_rst_n`=0.
- Checksum (macro on): sum off by 1 → `error`=1 and `cpu_rst_n` never rises. Reset asserted mid-LOAD → all outputs return to their reset values asynchronously.
